// File: rtl/pipe_ctrl_unit.sv
// ============================================================================
// Module   : pipe_ctrl_unit
// Brief    : Pipelined main decoder with ID/EX, EX/MEM, MEM/WB control stages,
//            load-use stall, branch flush and saturating stall counter.
//            Optional JAL/JALR decode enabled by macro CU_JUMP_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_unit #(
   parameter int REG_AW  = 5,
   parameter int ALUOP_W = 2,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         opcode_id,
   input  logic [REG_AW-1:0]  rs1_id,
   input  logic [REG_AW-1:0]  rs2_id,
   input  logic [REG_AW-1:0]  rd_id,
   input  logic               branch_taken_ex,
   output logic               stall_o,
   output logic               flush_o,
   output logic               illegal_id,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic               ex_alu_src,
   output logic               ex_branch,
   output logic               ex_jump,
   output logic               ex_mem_read,
   output logic [REG_AW-1:0]  ex_rd,
   output logic               mem_read,
   output logic               mem_write,
   output logic               mem_reg_write,
   output logic [REG_AW-1:0]  mem_rd,
   output logic               wb_reg_write,
   output logic               wb_mem_to_reg,
   output logic [REG_AW-1:0]  wb_rd,
   output logic [CNT_W-1:0]   stall_cnt
);

   localparam logic [6:0] c_op_r      = 7'b0110011;
   localparam logic [6:0] c_op_load   = 7'b0000011;
   localparam logic [6:0] c_op_store  = 7'b0100011;
   localparam logic [6:0] c_op_branch = 7'b1100011;
   localparam logic [6:0] c_op_ialu   = 7'b0010011;
`ifdef CU_JUMP_EN
   localparam logic [6:0] c_op_jal    = 7'b1101111;
   localparam logic [6:0] c_op_jalr   = 7'b1100111;
`endif

   logic [ALUOP_W-1:0] w_alu_op;
   logic               w_alu_src, w_branch, w_mem_read, w_mem_write;
   logic               w_reg_write, w_mem_to_reg, w_rs1_used, w_rs2_used;
   logic               w_hazard, w_bubble;
`ifdef CU_JUMP_EN
   logic               w_jump;
   logic               r_ex_jump;
`endif

   logic [ALUOP_W-1:0] r_ex_alu_op;
   logic               r_ex_alu_src, r_ex_branch, r_ex_mem_read, r_ex_mem_write;
   logic               r_ex_reg_write, r_ex_mem_to_reg;
   logic [REG_AW-1:0]  r_ex_rd;
   logic               r_mem_read, r_mem_write, r_mem_reg_write, r_mem_mem_to_reg;
   logic [REG_AW-1:0]  r_mem_rd;
   logic               r_wb_reg_write, r_wb_mem_to_reg;
   logic [REG_AW-1:0]  r_wb_rd;
   logic [CNT_W-1:0]   r_stall_cnt;

   always_comb begin
      w_alu_op     = '0;
      w_alu_src    = 1'b0;
      w_branch     = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_reg_write  = 1'b0;
      w_mem_to_reg = 1'b0;
      w_rs1_used   = 1'b0;
      w_rs2_used   = 1'b0;
      illegal_id   = 1'b0;
`ifdef CU_JUMP_EN
      w_jump       = 1'b0;
`endif
      case (opcode_id)
         c_op_r: begin
            w_alu_op = ALUOP_W'(2'b10);
            w_reg_write = 1'b1;
            w_rs1_used = 1'b1;
            w_rs2_used = 1'b1;
         end
         c_op_load: begin
            w_alu_src = 1'b1;
            w_mem_read = 1'b1;
            w_reg_write = 1'b1;
            w_mem_to_reg = 1'b1;
            w_rs1_used = 1'b1;
         end
         c_op_store: begin
            w_alu_src = 1'b1;
            w_mem_write = 1'b1;
            w_rs1_used = 1'b1;
            w_rs2_used = 1'b1;
         end
         c_op_branch: begin
            w_alu_op = ALUOP_W'(2'b01);
            w_branch = 1'b1;
            w_rs1_used = 1'b1;
            w_rs2_used = 1'b1;
         end
         c_op_ialu: begin
            w_alu_op = ALUOP_W'(2'b11);
            w_alu_src = 1'b1;
            w_reg_write = 1'b1;
            w_rs1_used = 1'b1;
         end
`ifdef CU_JUMP_EN
         c_op_jal: begin
            w_jump = 1'b1;
            w_reg_write = 1'b1;
         end
         c_op_jalr: begin
            w_alu_src = 1'b1;
            w_jump = 1'b1;
            w_reg_write = 1'b1;
            w_rs1_used = 1'b1;
         end
`endif
         default: illegal_id = 1'b1;
      endcase
   end

   // Only a live load in ID/EX can stall; a bubble has mem_read=0 and rd=0.
   assign w_hazard = r_ex_mem_read && (r_ex_rd != '0) &&
                     (((r_ex_rd == rs1_id) && w_rs1_used) ||
                      ((r_ex_rd == rs2_id) && w_rs2_used));
   assign flush_o  = branch_taken_ex;
   assign stall_o  = w_hazard && !branch_taken_ex;
   assign w_bubble = w_hazard || branch_taken_ex || illegal_id;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ex_alu_op      <= '0;
         r_ex_alu_src     <= 1'b0;
         r_ex_branch      <= 1'b0;
         r_ex_mem_read    <= 1'b0;
         r_ex_mem_write   <= 1'b0;
         r_ex_reg_write   <= 1'b0;
         r_ex_mem_to_reg  <= 1'b0;
         r_ex_rd          <= '0;
         r_mem_read       <= 1'b0;
         r_mem_write      <= 1'b0;
         r_mem_reg_write  <= 1'b0;
         r_mem_mem_to_reg <= 1'b0;
         r_mem_rd         <= '0;
         r_wb_reg_write   <= 1'b0;
         r_wb_mem_to_reg  <= 1'b0;
         r_wb_rd          <= '0;
         r_stall_cnt      <= '0;
      end else begin
         r_ex_alu_op      <= w_bubble ? '0 : w_alu_op;
         r_ex_alu_src     <= !w_bubble && w_alu_src;
         r_ex_branch      <= !w_bubble && w_branch;
         r_ex_mem_read    <= !w_bubble && w_mem_read;
         r_ex_mem_write   <= !w_bubble && w_mem_write;
         r_ex_reg_write   <= !w_bubble && w_reg_write;
         r_ex_mem_to_reg  <= !w_bubble && w_mem_to_reg;
         r_ex_rd          <= w_bubble ? '0 : rd_id;
         r_mem_read       <= r_ex_mem_read;
         r_mem_write      <= r_ex_mem_write;
         r_mem_reg_write  <= r_ex_reg_write;
         r_mem_mem_to_reg <= r_ex_mem_to_reg;
         r_mem_rd         <= r_ex_rd;
         r_wb_reg_write   <= r_mem_reg_write;
         r_wb_mem_to_reg  <= r_mem_mem_to_reg;
         r_wb_rd          <= r_mem_rd;
         if (stall_o && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

`ifdef CU_JUMP_EN
   always_ff @(posedge clk) begin
      if (reset)
         r_ex_jump <= 1'b0;
      else
         r_ex_jump <= !w_bubble && w_jump;
   end
   assign ex_jump = r_ex_jump;
`else
   assign ex_jump = 1'b0;
`endif

   assign ex_alu_op     = r_ex_alu_op;
   assign ex_alu_src    = r_ex_alu_src;
   assign ex_branch     = r_ex_branch;
   assign ex_mem_read   = r_ex_mem_read;
   assign ex_rd         = r_ex_rd;
   assign mem_read      = r_mem_read;
   assign mem_write     = r_mem_write;
   assign mem_reg_write = r_mem_reg_write;
   assign mem_rd        = r_mem_rd;
   assign wb_reg_write  = r_wb_reg_write;
   assign wb_mem_to_reg = r_wb_mem_to_reg;
   assign wb_rd         = r_wb_rd;
   assign stall_cnt     = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
// ============================================================================
// Module   : tb_pipe_ctrl_unit
// Brief    : Directed bench for pipe_ctrl_unit with an instruction-level model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl_unit;

   localparam int CNT_W = 4;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_IALU = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] opcode_id;
   logic [4:0] rs1_id, rs2_id, rd_id;
   logic       branch_taken_ex;
   logic       stall_o, flush_o, illegal_id;
   logic [1:0] ex_alu_op;
   logic       ex_alu_src, ex_branch, ex_jump, ex_mem_read;
   logic [4:0] ex_rd;
   logic       mem_read, mem_write, mem_reg_write;
   logic [4:0] mem_rd;
   logic       wb_reg_write, wb_mem_to_reg;
   logic [4:0] wb_rd;
   logic [CNT_W-1:0] stall_cnt;

   int errors = 0;
   int checks = 0;

   pipe_ctrl_unit #(.REG_AW(5), .ALUOP_W(2), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .opcode_id(opcode_id), .rs1_id(rs1_id),
      .rs2_id(rs2_id), .rd_id(rd_id), .branch_taken_ex(branch_taken_ex),
      .stall_o(stall_o), .flush_o(flush_o), .illegal_id(illegal_id),
      .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
      .ex_jump(ex_jump), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .mem_read(mem_read), .mem_write(mem_write), .mem_reg_write(mem_reg_write),
      .mem_rd(mem_rd), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
      .wb_rd(wb_rd), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // {legal, aluop[1:0], alusrc, branch, jump, memread, memwrite, regwrite, memtoreg, rs1 used, rs2 used}
   typedef struct packed {
      logic       legal;
      logic [1:0] aluop;
      logic       src, br, jmp, mr, mw, rw, m2r, u1, u2;
   } dec_t;

   typedef struct packed {
      logic       v;
      logic [6:0] op;
      logic [4:0] rd;
   } ins_t;

   function automatic dec_t dec(input logic [6:0] op);
      dec_t d;
      d = '0;
      case (op)
         7'b0110011: d = 12'b1_10_0_0_0_0_0_1_0_1_1;
         7'b0000011: d = 12'b1_00_1_0_0_1_0_1_1_1_0;
         7'b0100011: d = 12'b1_00_1_0_0_0_1_0_0_1_1;
         7'b1100011: d = 12'b1_01_0_1_0_0_0_0_0_1_1;
         7'b0010011: d = 12'b1_11_1_0_0_0_0_1_0_1_0;
`ifdef CU_JUMP_EN
         7'b1101111: d = 12'b1_00_0_0_1_0_0_1_0_0_0;
         7'b1100111: d = 12'b1_00_1_0_1_0_0_1_0_1_0;
`endif
         default: d = '0;
      endcase
      return d;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction-level model: each stage holds the instruction occupying it.
   ins_t m_ex, m_mem, m_wb;
   int   m_stalls;
   bit   m_live = 1'b0;

   always begin : compare
      dec_t din, dex, dmem, dwb;
      logic haz, br;
      ins_t n_ex, n_mem, n_wb;
      @(negedge clk);
      din  = dec(opcode_id);
      dex  = m_ex.v  ? dec(m_ex.op)  : '0;
      dmem = m_mem.v ? dec(m_mem.op) : '0;
      dwb  = m_wb.v  ? dec(m_wb.op)  : '0;
      br   = branch_taken_ex;
      haz  = dex.mr && (m_ex.rd != 5'd0) &&
             ((m_ex.rd == rs1_id && din.u1) || (m_ex.rd == rs2_id && din.u2));
      if (m_live) begin
         check("stall_o", stall_o, haz && !br);
         check("flush_o", flush_o, br);
         check("illegal_id", illegal_id, !din.legal);
         check("ex_alu_op", ex_alu_op, dex.aluop);
         check("ex_alu_src", ex_alu_src, dex.src);
         check("ex_branch", ex_branch, dex.br);
         check("ex_jump", ex_jump, dex.jmp);
         check("ex_mem_read", ex_mem_read, dex.mr);
         check("ex_rd", ex_rd, m_ex.v ? m_ex.rd : 5'd0);
         check("mem_read", mem_read, dmem.mr);
         check("mem_write", mem_write, dmem.mw);
         check("mem_reg_write", mem_reg_write, dmem.rw);
         check("mem_rd", mem_rd, m_mem.v ? m_mem.rd : 5'd0);
         check("wb_reg_write", wb_reg_write, dwb.rw);
         check("wb_mem_to_reg", wb_mem_to_reg, dwb.m2r);
         check("wb_rd", wb_rd, m_wb.v ? m_wb.rd : 5'd0);
         check("stall_cnt", stall_cnt, (m_stalls > 15) ? 15 : m_stalls);
      end
      n_wb  = m_mem;
      n_mem = m_ex;
      n_ex  = (haz || br || !din.legal) ? '0 : {1'b1, opcode_id, rd_id};
      @(posedge clk);
      if (reset) begin
         m_ex = '0; m_mem = '0; m_wb = '0; m_stalls = 0; m_live = 1'b1;
      end else begin
         m_ex = n_ex; m_mem = n_mem; m_wb = n_wb;
         if (haz && !br) m_stalls++;
      end
   end

   task automatic set_in(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic br);
      opcode_id = op; rs1_id = r1; rs2_id = r2; rd_id = rd; branch_taken_ex = br;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd);
      set_in(op, r1, r2, rd, 1'b0);
      tick();
   endtask

   initial begin : watchdog
      #200000;
      errors++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : stim
      reset = 1'b1;
      set_in(7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      tick(); tick();
      check("rst_stall_cnt", stall_cnt, 0);
      check("rst_ex_alu_op", ex_alu_op, 0);
      check("rst_wb_rd", wb_rd, 0);
      reset = 1'b0;

      // Hazard-free stream of each legal class.
      issue(OP_R, 5'd2, 5'd3, 5'd1);
      check("lit_r_ex_alu_op", ex_alu_op, 2);
      check("lit_r_ex_rd", ex_rd, 1);
      issue(OP_LD, 5'd2, 5'd0, 5'd10);
      check("lit_r_mem_reg_write", mem_reg_write, 1);
      issue(OP_ST, 5'd3, 5'd4, 5'd11);
      check("lit_r_wb_rd", wb_rd, 1);
      issue(OP_BR, 5'd5, 5'd6, 5'd12);
      issue(OP_IALU, 5'd8, 5'd0, 5'd7);
      issue(OP_IALU, 5'd0, 5'd0, 5'd0);

      // lw x5 ; add x6,x5,x7
      issue(OP_LD, 5'd1, 5'd0, 5'd5);
      set_in(OP_R, 5'd5, 5'd7, 5'd6, 1'b0);
      #1 check("lit_lu_stall", stall_o, 1);
      tick();
      check("lit_lu_bubble_rd", ex_rd, 0);
      check("lit_lu_stall_after", stall_o, 0);
      tick();
      check("lit_lu_add_ex_rd", ex_rd, 6);
      check("lit_lu_cnt", stall_cnt, 1);

      // No stall: load to x0, and rs2 field of an I-type.
      issue(OP_LD, 5'd1, 5'd0, 5'd0);
      set_in(OP_R, 5'd0, 5'd0, 5'd9, 1'b0);
      #1 check("lit_x0_nostall", stall_o, 0);
      tick();
      issue(OP_LD, 5'd1, 5'd0, 5'd5);
      set_in(OP_IALU, 5'd9, 5'd5, 5'd10, 1'b0);
      #1 check("lit_rs2_nostall", stall_o, 0);
      tick();

      // Flush coinciding with a load-use hazard.
      issue(OP_LD, 5'd1, 5'd0, 5'd5);
      set_in(OP_R, 5'd5, 5'd5, 5'd6, 1'b1);
      #1 check("lit_fl_flush", flush_o, 1);
      check("lit_fl_stall", stall_o, 0);
      tick();
      check("lit_fl_bubble", ex_alu_op, 0);
      check("lit_fl_cnt", stall_cnt, 1);
      issue(OP_R, 5'd5, 5'd5, 5'd6);

      // JAL: legal only with the jump option.
      set_in(OP_JAL, 5'd1, 5'd2, 5'd3, 1'b0);
`ifdef CU_JUMP_EN
      #1 check("lit_jal_illegal", illegal_id, 0);
      tick();
      check("lit_jal_ex_jump", ex_jump, 1);
      issue(OP_IALU, 5'd0, 5'd0, 5'd0);
      issue(OP_IALU, 5'd0, 5'd0, 5'd0);
      check("lit_jal_wb_rw", wb_reg_write, 1);
`else
      #1 check("lit_jal_illegal", illegal_id, 1);
      tick();
      check("lit_jal_ex_jump", ex_jump, 0);
      issue(OP_IALU, 5'd0, 5'd0, 5'd0);
      issue(OP_IALU, 5'd0, 5'd0, 5'd0);
      check("lit_jal_wb_rw", wb_reg_write, 0);
`endif
      set_in(7'h7f, 5'd0, 5'd0, 5'd0, 1'b0);
      #1 check("lit_7f_illegal", illegal_id, 1);
      tick();

      // Two dependent loads then a use of the second.
      issue(OP_LD, 5'd1, 5'd0, 5'd5);
      set_in(OP_LD, 5'd5, 5'd0, 5'd6, 1'b0);
      tick(); tick();
      set_in(OP_R, 5'd6, 5'd2, 5'd7, 1'b0);
      #1 check("lit_dl_stall", stall_o, 1);
      tick(); tick();
      check("lit_dl_cnt", stall_cnt, 3);

      // Saturation: 2^CNT_W + 3 hazards.
      for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
         issue(OP_LD, 5'd1, 5'd0, 5'd5);
         set_in(OP_R, 5'd5, 5'd5, 5'd6, 1'b0);
         tick(); tick();
      end
      check("lit_sat_cnt", stall_cnt, 15);

      // Reset while stalled.
      issue(OP_LD, 5'd1, 5'd0, 5'd5);
      set_in(OP_R, 5'd5, 5'd5, 5'd6, 1'b0);
      reset = 1'b1;
      #1 check("lit_rs_stall_before", stall_o, 1);
      tick();
      check("lit_rs_stall", stall_o, 0);
      check("lit_rs_cnt", stall_cnt, 0);
      check("lit_rs_ex_mr", ex_mem_read, 0);
      check("lit_rs_mem_rd", mem_rd, 0);
      reset = 1'b0;
      issue(OP_R, 5'd1, 5'd2, 5'd3);
      issue(OP_IALU, 5'd0, 5'd0, 5'd0);
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
